// File: rtl/matmul_feeder_if.sv
// Stream bundle between the matrix feeder and its producer/consumer:
// element beats in, result beats out.
interface matmul_feeder_if #(
  parameter int S = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [S-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [S-1:0] out_data;
  logic         out_last;

  // slave: the feeder itself; master: whoever streams operands in and results out
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matmul_feeder.sv
// Collects A and B element beats, launches the matmul engine, waits for its
// result (with timeout) and streams O back out one element per beat.
module matmul_feeder #(
  parameter int S       = 32,
  parameter int H       = 2,
  parameter int C       = 2,
  parameter int W       = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  matmul_feeder_if.slave     bus,
  output logic               mm_start,
  output logic [H*C*S-1:0]   mm_a,
  output logic [C*W*S-1:0]   mm_b,
  input  logic [H*W*S-1:0]   mm_o,
  input  logic               mm_done,
  output logic               busy,
  output logic               timeout
);
  localparam int NA   = H * C;
  localparam int NB   = C * W;
  localparam int NO   = H * W;
  localparam int NMAX = (NA > NB) ? NA : NB;
  localparam int IW   = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int OW   = (NO > 1) ? $clog2(NO) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [2:0] LOAD_A = 3'd0;
  localparam logic [2:0] LOAD_B = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] UNLOAD = 3'd4;

  logic [2:0]    state_reg;
  logic [IW-1:0] idx_reg;
  logic [OW-1:0] out_idx_reg;
  logic [TW-1:0] wait_cnt_reg;
  logic          timeout_reg;
  logic [S-1:0]  a_reg   [NA];
  logic [S-1:0]  b_reg   [NB];
  logic [S-1:0]  res_reg [NO];

  logic accept, a_wr, b_wr, capture, expire, out_fire;

  // Outputs are masked while rst is held so nothing leaks out mid-reset.
  assign bus.in_ready  = !rst && (state_reg == LOAD_A || state_reg == LOAD_B);
  assign bus.out_valid = !rst && (state_reg == UNLOAD);
  assign bus.out_data  = res_reg[out_idx_reg];
  assign bus.out_last  = bus.out_valid && (out_idx_reg == OW'(NO - 1));
  assign mm_start      = !rst && (state_reg == START);
  assign busy          = !rst && (state_reg != LOAD_A);
  assign timeout       = !rst && timeout_reg;

  assign accept   = bus.in_valid && bus.in_ready;
  assign a_wr     = accept && (state_reg == LOAD_A);
  assign b_wr     = accept && (state_reg == LOAD_B);
  // wait_cnt_reg==0 is the first WAIT cycle, where a stale done level is ignored
  assign capture  = (state_reg == WAIT) && (wait_cnt_reg != '0) && mm_done;
  assign expire   = (state_reg == WAIT) && !capture && (wait_cnt_reg == TW'(TIMEOUT - 1));
  assign out_fire = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= LOAD_A;
      idx_reg      <= '0;
      out_idx_reg  <= '0;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        LOAD_A: if (a_wr) begin
          if (idx_reg == IW'(NA - 1)) begin
            idx_reg   <= '0;
            state_reg <= LOAD_B;
          end else begin
            idx_reg <= idx_reg + IW'(1);
          end
        end
        LOAD_B: if (b_wr) begin
          if (idx_reg == IW'(NB - 1)) begin
            idx_reg   <= '0;
            state_reg <= START;
          end else begin
            idx_reg <= idx_reg + IW'(1);
          end
        end
        START: begin
          wait_cnt_reg <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          if (capture) begin
            state_reg <= UNLOAD;
          end else if (expire) begin
            timeout_reg <= 1'b1;
            state_reg   <= LOAD_A;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + TW'(1);
          end
        end
        UNLOAD: if (out_fire) begin
          if (out_idx_reg == OW'(NO - 1)) begin
            out_idx_reg <= '0;
            state_reg   <= LOAD_A;
          end else begin
            out_idx_reg <= out_idx_reg + OW'(1);
          end
        end
        default: state_reg <= LOAD_A;
      endcase
    end
  end

  // Element k lives in slot k; the packed buses put element 0 in the MSBs.
  genvar gi;
  generate
    for (gi = 0; gi < NA; gi++) begin : g_a
      always_ff @(posedge clk) begin
        if (rst || expire)
          a_reg[gi] <= '0;
        else if (a_wr && idx_reg == IW'(gi))
          a_reg[gi] <= bus.in_data;
      end
      assign mm_a[(NA-1-gi)*S +: S] = a_reg[gi];
    end
    for (gi = 0; gi < NB; gi++) begin : g_b
      always_ff @(posedge clk) begin
        if (rst || expire)
          b_reg[gi] <= '0;
        else if (b_wr && idx_reg == IW'(gi))
          b_reg[gi] <= bus.in_data;
      end
      assign mm_b[(NB-1-gi)*S +: S] = b_reg[gi];
    end
    for (gi = 0; gi < NO; gi++) begin : g_o
      always_ff @(posedge clk) begin
        if (rst)
          res_reg[gi] <= '0;
        else if (capture)
          res_reg[gi] <= mm_o[(NO-1-gi)*S +: S];
      end
    end
  endgenerate
endmodule

// File: tb/tb_matmul_feeder.sv
// Bench for matmul_feeder: table-driven load/unload transactions against a
// stub engine, scoreboarded output beats, and hand-written corner sequences.
module tb_matmul_feeder;
  localparam int S  = 32;
  localparam int H  = 2;
  localparam int C  = 2;
  localparam int W  = 2;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mm_start, busy, timeout;
  logic         mm_done = 1'b0;
  logic [127:0] mm_a, mm_b;
  logic [127:0] mm_o = '0;

  always #5 clk = ~clk;

  matmul_feeder_if #(.S(S)) bus ();

  matmul_feeder #(.S(S), .H(H), .C(C), .W(W), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mm_start (mm_start),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .mm_o     (mm_o),
    .mm_done  (mm_done),
    .busy     (busy),
    .timeout  (timeout)
  );

  typedef struct {
    logic [255:0] ab;     // 8 input beats, beat 0 in the MSBs
    logic [127:0] o;      // stub result, slot 0 in the MSBs
    logic [127:0] exp_a;
    logic [127:0] exp_b;
    bit           gappy;
    bit           stall;
  } vec_t;

  vec_t         vecs [3];
  logic [31:0]  load_buf [8];
  logic [32:0]  sb [$];   // {last, data}
  int           checks = 0;
  int           errors = 0;
  int           start_count = 0;
  logic [127:0] cap_a, cap_b, held_a;
  bit           stub_en = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stub engine: drops done at start, raises it (and leaves it high) 3 cycles later.
  always begin
    @(negedge clk);
    if (stub_en && mm_start === 1'b1) begin
      mm_done = 1'b0;
      repeat (3) @(negedge clk);
      mm_done = 1'b1;
    end
  end

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (mm_start === 1'b1) begin
      start_count++;
      cap_a = mm_a;
      cap_b = mm_b;
    end
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("out_data", bus.out_data, sb[0][31:0]);
        check("out_last", bus.out_last, sb[0][32]);
        if (bus.out_ready) begin
          if (sb[0][32]) held_a = mm_a;
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic load(input int n, input bit gappy);
    int guard;
    for (int i = 0; i < n; i++) begin
      bus.in_data  = load_buf[i];
      bus.in_valid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) check("in_ready_wait", 0, 1);
      tick();
      if (gappy) begin
        bus.in_valid = 1'b0;
        tick();
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sb.size() != 0 && g < 300) begin
      tick();
      g++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    repeat (2) tick();
  endtask

  task automatic wait_start();
    int g = 0;
    @(negedge clk);
    while (mm_start !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("mm_start_wait", 0, 1);
  endtask

  task automatic push_expected(input logic [127:0] o);
    logic [127:0] tmp;
    tmp = o;
    for (int k = 0; k < 4; k++)
      sb.push_back({(k == 3), tmp[(3-k)*32 +: 32]});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_mm_start", mm_start, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_timeout", timeout, 0);
    check("rst_mm_a", mm_a, 0);
    check("rst_mm_b", mm_b, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    tick();
  endtask

  task automatic run_vec(input int v);
    vec_t t;
    int   s0;
    int   g;
    t  = vecs[v];
    s0 = start_count;
    mm_o = t.o;
    push_expected(t.o);
    for (int i = 0; i < 8; i++) load_buf[i] = t.ab[(7-i)*32 +: 32];
    load(8, t.gappy);
    if (t.stall) begin
      g = 0;
      @(negedge clk);
      while (bus.out_valid !== 1'b1 && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) check("out_valid_wait", 0, 1);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      repeat (5) tick();
      bus.out_ready = 1'b1;
    end
    wait_drain();
    check("start_pulses", start_count - s0, 1);
    check("mm_a", cap_a, t.exp_a);
    check("mm_b", cap_b, t.exp_b);
    check("mm_a_hold", held_a, t.exp_a);
    $display("vec %0d: A/B loaded, 4 result beats drained", v);
  endtask

  initial begin
    int s0;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    vecs[0].ab    = {8{32'h40a00000}};
    vecs[0].o     = {4{32'h42480000}};
    vecs[0].exp_a = {4{32'h40a00000}};
    vecs[0].exp_b = {4{32'h40a00000}};
    vecs[0].gappy = 1'b0;
    vecs[0].stall = 1'b0;

    vecs[1].ab    = {32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
                     32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000};
    vecs[1].o     = {32'h41980000, 32'h41b00000, 32'h422c0000, 32'h42480000};
    vecs[1].exp_a = {32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};
    vecs[1].exp_b = {32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000};
    vecs[1].gappy = 1'b0;
    vecs[1].stall = 1'b0;

    vecs[2].ab    = {32'hbf800000, 32'h3fc00000, 32'hc0200000, 32'h40490fdb,
                     32'h00000000, 32'h7f7fffff, 32'h80000001, 32'h3eaaaaab};
    vecs[2].o     = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d};
    vecs[2].exp_a = {32'hbf800000, 32'h3fc00000, 32'hc0200000, 32'h40490fdb};
    vecs[2].exp_b = {32'h00000000, 32'h7f7fffff, 32'h80000001, 32'h3eaaaaab};
    vecs[2].gappy = 1'b1;
    vecs[2].stall = 1'b1;

    tick();
    do_reset();

    for (int v = 0; v < 3; v++) run_vec(v);

    // Stale done level: first WAIT cycle must ignore it, second captures.
    stub_en = 1'b0;
    mm_done = 1'b1;
    mm_o    = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    push_expected(mm_o);
    for (int i = 0; i < 8; i++) load_buf[i] = 32'h3f800000 + i;
    load(8, 1'b0);
    wait_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.out_valid !== 1'b1 && n < 20);
    check("stale_done_latency", n, 3);
    @(posedge clk);
    #1;
    wait_drain();
    mm_done = 1'b0;
    stub_en = 1'b1;
    $display("stale done: capture latency %0d cycles after start", n);

    // Reset after 5 of 8 beats aborts the load.
    for (int i = 0; i < 8; i++) load_buf[i] = 32'habc00000 + i;
    load(5, 1'b0);
    s0 = start_count;
    do_reset();
    repeat (10) tick();
    check("abort_no_start", start_count - s0, 0);
    $display("reset mid-load: aborted");
    run_vec(1);

    // Timeout: engine never answers.
    stub_en = 1'b0;
    mm_done = 1'b0;
    for (int i = 0; i < 8; i++) load_buf[i] = 32'h40000000 + i;
    load(8, 1'b0);
    wait_start();
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) begin
        check("to_not_yet", timeout, 0);
        check("to_busy_wait", busy, 1);
      end
      if (k == 17) begin
        check("to_flag", timeout, 1);
        check("to_busy", busy, 0);
        check("to_in_ready", bus.in_ready, 1);
        check("to_discard_a", mm_a, 0);
      end
    end
    @(posedge clk);
    #1;
    repeat (5) tick();
    @(negedge clk);
    check("to_sticky", timeout, 1);
    @(posedge clk);
    #1;
    stub_en = 1'b1;
    $display("timeout: flag raised after %0d wait cycles", TO);
    do_reset();

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
